// File: rtl/debug_command_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : debug_command_sequencer
//  Description : Byte-stream command sequencer for a debug decoder. It takes
//                a command byte (plus two data bytes for writes), issues one
//                strobed operation and waits for completion or a timeout. It
//                then returns either the 16-bit read result or a status byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_command_sequencer (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [7:0]  RX_DATA_I,
    input  logic        RX_VALID_I,
    output logic        RX_READY_O,
    output logic [7:0]  TX_DATA_O,
    output logic        TX_VALID_O,
    input  logic        TX_READY_I,
    output logic [2:0]  DEBUG_OP_O,
    output logic [2:0]  DEBUG_ARG_O,
    output logic        DEBUG_ADDR_INC_O,
    output logic        DEBUG_EN_BKP_O,
    output logic [15:0] DEBUG_DIN_O,
    output logic        DEBUG_STROBE_O,
    input  logic        DEBUG_DONE_I,
    input  logic [15:0] DEBUG_DOUT_I
);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WR_BKP = 3'd1;
    localparam logic [2:0] OP_WR_MEM = 3'd7;
    localparam logic [7:0] ACK_OK    = 8'hA5;
    localparam logic [7:0] ACK_ERR   = 8'hEE;
    localparam logic [7:0] TMO_LAST  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA_HI = 3'd1,
        ST_DATA_LO = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_TX_HI   = 3'd5,
        ST_TX_LO   = 3'd6,
        ST_TX_ACK  = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [2:0]  arg_q, arg_d;
    logic        inc_q, inc_d;
    logic        bkp_q, bkp_d;
    logic [15:0] din_q, din_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  tmo_q, tmo_d;

    logic        rx_ready_w;
    logic        op_is_write_w;

    assign op_is_write_w = (op_q == OP_WR_BKP) || (op_q == OP_WR_MEM);

    // Ready is forced low while reset is held so no byte can appear accepted.
    assign RX_READY_O  = rx_ready_w & RESET_N;
    assign DEBUG_DIN_O = din_q;

    // Next-state and output decode for the command/response sequence.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        arg_d            = arg_q;
        inc_d            = inc_q;
        bkp_d            = bkp_q;
        din_d            = din_q;
        rdata_d          = rdata_q;
        err_d            = err_q;
        tmo_d            = tmo_q;
        rx_ready_w       = 1'b0;
        TX_VALID_O       = 1'b0;
        TX_DATA_O        = 8'h00;
        DEBUG_STROBE_O   = 1'b0;
        DEBUG_OP_O       = OP_NOP;
        DEBUG_ARG_O      = 3'd0;
        DEBUG_ADDR_INC_O = 1'b0;
        DEBUG_EN_BKP_O   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rx_ready_w = 1'b1;
                if (RX_VALID_I) begin
                    op_d  = RX_DATA_I[7:5];
                    arg_d = RX_DATA_I[4:2];
                    inc_d = RX_DATA_I[1];
                    bkp_d = RX_DATA_I[0];
                    err_d = 1'b0;
                    if ((RX_DATA_I[7:5] == OP_WR_BKP) || (RX_DATA_I[7:5] == OP_WR_MEM)) begin
                        state_d = ST_DATA_HI;
                    end else if (RX_DATA_I[7:5] == OP_NOP) begin
                        state_d = ST_TX_ACK;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DATA_HI: begin
                rx_ready_w = 1'b1;
                if (RX_VALID_I) begin
                    din_d[15:8] = RX_DATA_I;
                    state_d     = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                rx_ready_w = 1'b1;
                if (RX_VALID_I) begin
                    din_d[7:0] = RX_DATA_I;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                DEBUG_STROBE_O   = 1'b1;
                DEBUG_OP_O       = op_q;
                DEBUG_ARG_O      = arg_q;
                DEBUG_ADDR_INC_O = inc_q;
                DEBUG_EN_BKP_O   = bkp_q;
                tmo_d            = 8'd0;
                state_d          = ST_WAIT;
            end
            ST_WAIT: begin
                DEBUG_OP_O       = op_q;
                DEBUG_ARG_O      = arg_q;
                DEBUG_ADDR_INC_O = inc_q;
                DEBUG_EN_BKP_O   = bkp_q;
                // Completion wins over a timeout landing in the same cycle.
                if (DEBUG_DONE_I) begin
                    if (op_is_write_w) begin
                        state_d = ST_TX_ACK;
                    end else begin
                        rdata_d = DEBUG_DOUT_I;
                        state_d = ST_TX_HI;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_TX_ACK;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_TX_HI: begin
                TX_VALID_O = 1'b1;
                TX_DATA_O  = rdata_q[15:8];
                if (TX_READY_I) begin
                    state_d = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                TX_VALID_O = 1'b1;
                TX_DATA_O  = rdata_q[7:0];
                if (TX_READY_I) begin
                    state_d = ST_IDLE;
                end
            end
            ST_TX_ACK: begin
                TX_VALID_O = 1'b1;
                TX_DATA_O  = err_q ? ACK_ERR : ACK_OK;
                if (TX_READY_I) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            arg_q   <= 3'd0;
            inc_q   <= 1'b0;
            bkp_q   <= 1'b0;
            din_q   <= 16'd0;
            rdata_q <= 16'd0;
            err_q   <= 1'b0;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            inc_q   <= inc_d;
            bkp_q   <= bkp_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_command_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debug_command_sequencer
//  Description : Directed self-checking bench for debug_command_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_command_sequencer;

    logic        CLK;
    logic        RESET_N;
    logic [7:0]  RX_DATA_I;
    logic        RX_VALID_I;
    logic        RX_READY_O;
    logic [7:0]  TX_DATA_O;
    logic        TX_VALID_O;
    logic        TX_READY_I;
    logic [2:0]  DEBUG_OP_O;
    logic [2:0]  DEBUG_ARG_O;
    logic        DEBUG_ADDR_INC_O;
    logic        DEBUG_EN_BKP_O;
    logic [15:0] DEBUG_DIN_O;
    logic        DEBUG_STROBE_O;
    logic        DEBUG_DONE_I;
    logic [15:0] DEBUG_DOUT_I;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;
    int s0;

    debug_command_sequencer dut (
        .CLK              (CLK),
        .RESET_N          (RESET_N),
        .RX_DATA_I        (RX_DATA_I),
        .RX_VALID_I       (RX_VALID_I),
        .RX_READY_O       (RX_READY_O),
        .TX_DATA_O        (TX_DATA_O),
        .TX_VALID_O       (TX_VALID_O),
        .TX_READY_I       (TX_READY_I),
        .DEBUG_OP_O       (DEBUG_OP_O),
        .DEBUG_ARG_O      (DEBUG_ARG_O),
        .DEBUG_ADDR_INC_O (DEBUG_ADDR_INC_O),
        .DEBUG_EN_BKP_O   (DEBUG_EN_BKP_O),
        .DEBUG_DIN_O      (DEBUG_DIN_O),
        .DEBUG_STROBE_O   (DEBUG_STROBE_O),
        .DEBUG_DONE_I     (DEBUG_DONE_I),
        .DEBUG_DOUT_I     (DEBUG_DOUT_I)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Strobe pulses counted mid-cycle, away from the active edge.
    always @(negedge CLK) begin
        if (DEBUG_STROBE_O === 1'b1) strobes++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        RX_DATA_I  = b;
        RX_VALID_I = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (RX_READY_O === 1'b1) break;
            step();
        end
        chk("rx_ready_before_send", {15'd0, RX_READY_O}, 16'd1);
        step();
        RX_VALID_I = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [7:0] exp);
        TX_READY_I = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (TX_VALID_O === 1'b1) break;
            step();
        end
        chk({tag, "_valid"}, {15'd0, TX_VALID_O}, 16'd1);
        chk(tag, {8'd0, TX_DATA_O}, {8'd0, exp});
        step();
        TX_READY_I = 1'b0;
    endtask

    task automatic done_pulse(input logic [15:0] dout);
        DEBUG_DONE_I = 1'b1;
        DEBUG_DOUT_I = dout;
        step();
        DEBUG_DONE_I = 1'b0;
        DEBUG_DOUT_I = 16'h0000;
    endtask

    initial begin
        RESET_N      = 1'b0;
        RX_DATA_I    = 8'h00;
        RX_VALID_I   = 1'b0;
        TX_READY_I   = 1'b0;
        DEBUG_DONE_I = 1'b0;
        DEBUG_DOUT_I = 16'h0000;

        // Reset state
        step(); step(); step();
        chk("rst_rx_ready", {15'd0, RX_READY_O}, 16'd0);
        chk("rst_tx_valid", {15'd0, TX_VALID_O}, 16'd0);
        chk("rst_tx_data",  {8'd0, TX_DATA_O}, 16'd0);
        chk("rst_strobe",   {15'd0, DEBUG_STROBE_O}, 16'd0);
        chk("rst_op",       {13'd0, DEBUG_OP_O}, 16'd0);
        chk("rst_din",      DEBUG_DIN_O, 16'd0);
        RESET_N = 1'b1;
        #1;
        chk("rel_rx_ready", {15'd0, RX_READY_O}, 16'd1);

        // RD_MEM 0xC6: OP=6 ARG=1 INC=1 EN=0, read data 0x1234
        s0 = strobes;
        send(8'hC6);
        chk("c6_strobe",  {15'd0, DEBUG_STROBE_O}, 16'd1);
        chk("c6_op",      {13'd0, DEBUG_OP_O}, 16'd6);
        chk("c6_arg",     {13'd0, DEBUG_ARG_O}, 16'd1);
        chk("c6_inc",     {15'd0, DEBUG_ADDR_INC_O}, 16'd1);
        chk("c6_bkp",     {15'd0, DEBUG_EN_BKP_O}, 16'd0);
        chk("c6_rx_rdy",  {15'd0, RX_READY_O}, 16'd0);
        step();
        chk("c6_wait_strobe", {15'd0, DEBUG_STROBE_O}, 16'd0);
        chk("c6_wait_op",     {13'd0, DEBUG_OP_O}, 16'd6);
        step(); step();
        done_pulse(16'h1234);
        recv("c6_tx_hi", 8'h12);
        recv("c6_tx_lo", 8'h34);
        chk("c6_idle_rdy",  {15'd0, RX_READY_O}, 16'd1);
        chk("c6_idle_op",   {13'd0, DEBUG_OP_O}, 16'd0);
        chk("c6_idle_tx",   {15'd0, TX_VALID_O}, 16'd0);
        chk("c6_strobes",   16'(strobes - s0), 16'd1);

        // WR_MEM 0xE2 0xBE 0xEF
        s0 = strobes;
        send(8'hE2);
        chk("e2_data_hi_rdy", {15'd0, RX_READY_O}, 16'd1);
        send(8'hBE);
        send(8'hEF);
        chk("e2_strobe", {15'd0, DEBUG_STROBE_O}, 16'd1);
        chk("e2_op",     {13'd0, DEBUG_OP_O}, 16'd7);
        chk("e2_din",    DEBUG_DIN_O, 16'hBEEF);
        chk("e2_inc",    {15'd0, DEBUG_ADDR_INC_O}, 16'd1);
        step();
        done_pulse(16'hFFFF);
        recv("e2_ack", 8'hA5);
        chk("e2_din_hold", DEBUG_DIN_O, 16'hBEEF);
        chk("e2_strobes",  16'(strobes - s0), 16'd1);

        // WR_BKP 0x25: OP=1 ARG=1 EN=1, DIN=0x0007
        send(8'h25);
        send(8'h00);
        send(8'h07);
        chk("25_op",  {13'd0, DEBUG_OP_O}, 16'd1);
        chk("25_arg", {13'd0, DEBUG_ARG_O}, 16'd1);
        chk("25_bkp", {15'd0, DEBUG_EN_BKP_O}, 16'd1);
        chk("25_din", DEBUG_DIN_O, 16'h0007);
        step();
        done_pulse(16'h0000);
        recv("25_ack", 8'hA5);

        // NOP 0x00: immediate ack, no strobe
        s0 = strobes;
        send(8'h00);
        chk("nop_op",    {13'd0, DEBUG_OP_O}, 16'd0);
        recv("nop_ack", 8'hA5);
        chk("nop_strobes", 16'(strobes - s0), 16'd0);

        // RD_PC 0x80 with no completion: timeout after exactly 256 WAIT cycles
        send(8'h80);
        step();
        for (int i = 0; i < 255; i++) step();
        chk("tmo_still_wait_tx", {15'd0, TX_VALID_O}, 16'd0);
        chk("tmo_still_wait_op", {13'd0, DEBUG_OP_O}, 16'd4);
        step();
        chk("tmo_tx_valid", {15'd0, TX_VALID_O}, 16'd1);
        chk("tmo_tx_data",  {8'd0, TX_DATA_O}, 16'h00EE);
        chk("tmo_op_nop",   {13'd0, DEBUG_OP_O}, 16'd0);
        recv("tmo_err", 8'hEE);
        send(8'h00);
        recv("after_tmo_ack", 8'hA5);

        // RD_REG 0x5C with TX back-pressure during TX_HI
        send(8'h5C);
        chk("5c_arg", {13'd0, DEBUG_ARG_O}, 16'd7);
        step();
        done_pulse(16'hABCD);
        DEBUG_DONE_I = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_tx_valid", {15'd0, TX_VALID_O}, 16'd1);
            chk("stall_tx_data",  {8'd0, TX_DATA_O}, 16'h00AB);
            chk("stall_rx_ready", {15'd0, RX_READY_O}, 16'd0);
            step();
        end
        DEBUG_DONE_I = 1'b0;
        recv("stall_tx_hi", 8'hAB);
        recv("stall_tx_lo", 8'hCD);

        // Reset during WAIT, then a late completion
        send(8'h60);
        step(); step(); step();
        s0 = strobes;
        RESET_N = 1'b0;
        step();
        chk("mid_rst_rx_ready", {15'd0, RX_READY_O}, 16'd0);
        chk("mid_rst_op",       {13'd0, DEBUG_OP_O}, 16'd0);
        chk("mid_rst_din",      DEBUG_DIN_O, 16'd0);
        RESET_N = 1'b1;
        #1;
        chk("mid_rel_rx_ready", {15'd0, RX_READY_O}, 16'd1);
        done_pulse(16'h5555);
        step(); step();
        chk("late_tx_valid", {15'd0, TX_VALID_O}, 16'd0);
        chk("late_tx_data",  {8'd0, TX_DATA_O}, 16'd0);
        chk("late_rx_ready", {15'd0, RX_READY_O}, 16'd1);
        chk("late_op",       {13'd0, DEBUG_OP_O}, 16'd0);
        chk("late_strobes",  16'(strobes - s0), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debug_command_sequencer.md
DEBUG_COMMAND_SEQUENCER -- requirements
Module: debug_command_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1: sole clock; all logic rising-edge.
REQ-002 SHALL have port RESET_N, input, 1: reset, synchronous and active-low.
REQ-003 SHALL have port RX_DATA_I, input, 8: command byte from the host link.
REQ-004 SHALL have port RX_VALID_I, input, 1: RX_DATA_I is valid.
REQ-005 SHALL have port RX_READY_O, output, 1: byte accepted when RX_VALID_I and RX_READY_O are both high.
REQ-006 SHALL have port TX_DATA_O, output, 8: response byte to the host link.
REQ-007 SHALL have port TX_VALID_O, output, 1: TX_DATA_O is valid; data is held stable until accepted.
REQ-008 SHALL have port TX_READY_I, input, 1: byte consumed when TX_VALID_O and TX_READY_I are both high.
REQ-009 SHALL have port DEBUG_OP_O, output, 3: operation code to the debug decoder.
REQ-010 SHALL have port DEBUG_ARG_O, output, 3: operation argument.
REQ-011 SHALL have port DEBUG_ADDR_INC_O, output, 1: auto-increment request.
REQ-012 SHALL have port DEBUG_EN_BKP_O, output, 1: breakpoint enable value.
REQ-013 SHALL have port DEBUG_DIN_O, output, 16: write data for WR_MEM and WR_BKP.
REQ-014 SHALL have port DEBUG_STROBE_O, output, 1: one-cycle pulse that starts an operation.
REQ-015 SHALL have port DEBUG_DONE_I, input, 1: operation complete; sampled only in WAIT.
REQ-016 SHALL have port DEBUG_DOUT_I, input, 16: read result, valid in the cycle DEBUG_DONE_I is high.

Function
REQ-017 Opcode values SHALL be: 0 NOP, 1 WR_BKP, 2 RD_REG, 3 RD_CC, 4 RD_PC, 5 RD_INSTRUCTION, 6 RD_MEM, 7 WR_MEM.
REQ-018 The command byte SHALL decode as:
  - [7:5] OP
  - [4:2] ARG
  - [1] ADDR_INC
  - [0] EN_BKP
REQ-019 The FSM states SHALL be IDLE, DATA_HI, DATA_LO, ISSUE, WAIT, TX_HI, TX_LO and TX_ACK.
REQ-020 RX_READY_O SHALL be high only in IDLE, DATA_HI and DATA_LO; it SHALL be low in all other states.
REQ-021 IDLE: an accepted byte SHALL latch OP, ARG, ADDR_INC and EN_BKP, then transition as follows:
  - OP = 1 or 7 -> DATA_HI
  - OP = 0 -> TX_ACK
  - any other OP -> ISSUE
REQ-022 DATA_HI: an accepted byte SHALL load DIN[15:8] and go to DATA_LO.
REQ-023 DATA_LO: an accepted byte SHALL load DIN[7:0] and go to ISSUE.
REQ-024 ISSUE SHALL last exactly one cycle, assert DEBUG_STROBE_O and go to WAIT.
REQ-025 DEBUG_OP_O, DEBUG_ARG_O, DEBUG_ADDR_INC_O and DEBUG_EN_BKP_O SHALL carry the latched values in ISSUE and WAIT, and SHALL be 0 (NOP) in all other states.
REQ-026 DEBUG_DIN_O SHALL hold the latched DIN at all times.
REQ-027 WAIT: on DEBUG_DONE_I, write ops (1, 7) SHALL go to TX_ACK; read ops SHALL capture DEBUG_DOUT_I into a 16-bit register and go to TX_HI.
REQ-028 WAIT SHALL run an 8-bit timeout counter, cleared on entry; if DEBUG_DONE_I has not occurred after 256 WAIT cycles, the block SHALL load error byte 0xEE and go to TX_ACK.
REQ-029 DEBUG_DONE_I SHALL take precedence over the timeout in the same cycle.
REQ-030 TX_HI SHALL present the captured data [15:8] and advance on TX handshake; TX_LO SHALL present [7:0] and return to IDLE on TX handshake.
REQ-031 TX_ACK SHALL present 0xA5 (success) or 0xEE (timeout) and return to IDLE on TX handshake.
REQ-032 TX_VALID_O SHALL be high only in TX_HI, TX_LO and TX_ACK; holding TX_READY_I low SHALL stall the FSM indefinitely with TX_DATA_O stable.
REQ-033 DEBUG_DONE_I outside WAIT SHALL be ignored.
REQ-034 At most one operation SHALL be outstanding at a time; a new command byte is accepted only after the previous response has fully transmitted.

Reset
REQ-035 While RESET_N is low at a clock edge, the block SHALL enter IDLE and clear every output and internal register:
  - RX_READY_O = 0 during reset
  - TX_VALID_O, DEBUG_STROBE_O, DEBUG_OP_O, DEBUG_ARG_O, DEBUG_ADDR_INC_O, DEBUG_EN_BKP_O, DEBUG_DIN_O, TX_DATA_O = 0
  - timeout counter = 0
REQ-036 Reset asserted mid-operation (any state) SHALL abort the operation without a response, and no DEBUG_STROBE_O SHALL follow reset release.
REQ-037 RX_READY_O SHALL go high in the first cycle after RESET_N is released.

Verification
REQ-038 RX 0xC6 (RD_MEM, ARG=1, INC=1); DONE after 3 cycles with DOUT=0x1234 -> exactly one STROBE with OP=6, ARG=1, INC=1; TX bytes 0x12 then 0x34; back to IDLE.
REQ-039 RX 0xE2, 0xBE, 0xEF (WR_MEM) -> DIN=0xBEEF at STROBE with OP=7; on DONE, TX 0xA5.
REQ-040 RX 0x00 -> no STROBE; TX 0xA5 immediately.
REQ-041 RX 0x80 (RD_PC) with DONE never asserted -> after 256 WAIT cycles TX 0xEE; OP returns to 0.
REQ-042 TX_READY_I held low for 10 cycles during TX_HI -> TX_DATA_O stable, RX_READY_O stays low, no byte lost.
REQ-043 RESET_N pulsed low during WAIT, then a late DONE arrives -> no TX byte, state IDLE, all outputs 0.
